sseg_scan_driver: RTL
=====================

Name: sseg_scan_driver

Overview:
Parametrised time-multiplexed seven-segment scan driver. It is the successor to the fixed 8-digit sseg_driver and adds:
- N digits and a programmable scan rate;
- per-digit blank and decimal-point control;
- PWM brightness;
- optional leading-zero blanking;
- tear-free double-buffered digit loading with an acknowledge pulse.

It sits between the display-data logic and the board's anode and cathode pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned (2..16)
DIV, 100000, clk cycles per digit slot (>=4)
BRIGHT_W, 4, width of brightness control
SEL_W, $clog2(NUM_DIGITS), digit-select width (localparam, derived)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active high
digits  in  NUM_DIGITS*6  digit codes; digit i at [6i+5:6i]; code bit[3:0] hex value, bit[4] DP on, bit[5] force blank
load  in  1  capture digits into the staging buffer this cycle
bright  in  BRIGHT_W  brightness; all ones = full on
lz_en  in  1  enable leading-zero blanking
load_ack  out  1  one-cycle pulse when staged data becomes active
count_en  out  1  one-cycle tick at the end of each digit slot
count_out  out  SEL_W  currently selected digit index
D_out  out  6  active code of the selected digit
sseg  out  7  cathodes {g,f,e,d,c,b,a}, active low
DP  out  1  decimal point, active low
AN  out  NUM_DIGITS  anodes, active low, one-hot-low

Behaviour:
- Reset, asynchronous:
  - pre=0, count_out=0, active and staging buffers 0, pending=0.
  - count_en=0, load_ack=0, AN=all 1, sseg=7'h7F, DP=1.
- Prescaler:
  - pre counts 0..DIV-1 and wraps.
  - count_en=1 exactly on the cycles where pre==DIV-1.
- count_out increments on count_en and wraps NUM_DIGITS-1 -> 0.
- Frame boundary: count_en=1 and count_out==NUM_DIGITS-1.
- Double buffer:
  - load=1 captures digits into staging and sets pending=1.
  - A load while pending is already set overwrites staging (latest wins).
  - At a frame boundary with pending=1, staging copies to active, pending clears, and load_ack pulses on the following cycle.
  - load on the boundary cycle itself: the active buffer takes the load-cycle digits directly. pending stays 0 and load_ack still pulses.
  - Data never changes mid-frame.
- D_out is combinational from the active buffer and count_out.
- Leading-zero blanking, when lz_en=1:
  - Scanning from digit NUM_DIGITS-1 down, each digit with value==0 and DP==0 is blanked until the first digit that fails that test.
  - Digit 0 is never LZ-blanked.
  - Per-digit bit[5] blank always applies, independent of lz_en.
- PWM:
  - on_time = ((bright+1)*DIV) >> BRIGHT_W, computed at width clog2(DIV)+BRIGHT_W+1 with no overflow.
  - The anode is enabled only while pre < on_time.
- Output stage:
  - AN, sseg and DP are registered with 1-cycle latency from count_out/pre.
  - AN[count_out]=0 when enabled and not blanked; all other AN bits are 1.
  - A blanked or PWM-off slot drives AN=all 1, sseg=7'h7F, DP=1.
- Hex map for sseg:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- DP output = ~code[4].
- Reset asserted mid-frame returns every output to its reset values immediately. Scanning restarts at digit 0 with pre=0 after release.

Decomposition:
- Package sseg_pkg holds:
  - code field localparams: VAL_LSB=0, DP_BIT=4, BLANK_BIT=5, CODE_W=6;
  - constant SEG_BLANK=7'h7F;
  - function hex_to_seg(input [3:0]) returning [6:0].
- One sub-module, sseg_hex_decoder: pure combinational 4->7 map, instantiated once on the selected digit.

Test Plan:
All scenarios use NUM_DIGITS=8, DIV=4, BRIGHT_W=2.
1. Reset: hold rst high for 3 cycles -> AN=8'hFF, sseg=7'h7F, DP=1, count_out=0, count_en=0. After release, count_en pulses every 4th cycle and count_out steps 0..7..0.
2. Scan: load digits 0..7 with bright=3 and lz_en=0 -> load_ack at the next frame boundary. Per slot, AN walks FE,FD,...,7F one cycle after count_out changes. Slot 1 gives sseg=1111001; slot 7 gives 1111000.
3. PWM: bright=1 gives on_time=2 -> in each 4-cycle slot AN is active for 2 cycles and all 1 for 2 cycles. bright=0 gives on_time=1, so 1 active cycle.
4. Leading zeros: load codes {d7..d0}=0,0,0,5,0,0,0,0 with lz_en=1 -> digits 7,6,5 blanked (AN stays FF in their slots). Digits 4..0 are shown as 5,0,0,0,0. With lz_en=0, all digits are shown.
5. Double buffer: load A mid-frame, then load B 2 cycles later -> active data is unchanged until the boundary, then B is shown with a single load_ack. load exactly on the boundary cycle -> new data shows from digit 0 and load_ack follows.
6. Force blank and DP: code 6'b010011 gives sseg=0110000 with DP=0. Code 6'b100011 gives AN=all 1 during its slot.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment scan driver.
// Holds the digit-code field layout, the blank pattern and the hex map.
package sseg_pkg;

    // Per-digit code: [3:0] hex value, [4] decimal point, [5] force blank
    localparam int VAL_LSB   = 0;
    localparam int DP_BIT    = 4;
    localparam int BLANK_BIT = 5;
    localparam int CODE_W    = 6;

    // Cathodes {g,f,e,d,c,b,a}, active low: all segments off
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            4'hF:    s = 7'b0001110;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sseg_scan_driver_hex_decoder.sv
// Hex digit to seven-segment cathode pattern, purely combinational.
// Ports: hex (4-bit value in), seg ({g..a} active-low cathodes out).
module sseg_hex_decoder
    import sseg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(hex);

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed N-digit seven-segment scan driver with PWM dimming,
// per-digit blank/DP, leading-zero blanking and double-buffered loading.
// Ports: clk, rst (async, active high); digits/load/bright/lz_en in;
// load_ack, count_en, count_out, D_out, sseg, DP, AN out (display active low).
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter  int NUM_DIGITS = 8,
    parameter  int DIV        = 100000,
    parameter  int BRIGHT_W   = 4,
    localparam int SEL_W      = $clog2(NUM_DIGITS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_DIGITS*CODE_W-1:0] digits,
    input  logic                         load,
    input  logic [BRIGHT_W-1:0]          bright,
    input  logic                         lz_en,
    output logic                         load_ack,
    output logic                         count_en,
    output logic [SEL_W-1:0]             count_out,
    output logic [CODE_W-1:0]            D_out,
    output logic [6:0]                   sseg,
    output logic                         DP,
    output logic [NUM_DIGITS-1:0]        AN
);

    localparam int PRE_W = $clog2(DIV);
    // Wide enough that (bright+1)*DIV never overflows
    localparam int OT_W  = PRE_W + BRIGHT_W + 1;

    logic [PRE_W-1:0]             pre;
    logic                         last_dig;
    logic                         frame_end;
    logic                         pending;
    logic [NUM_DIGITS*CODE_W-1:0] staging;
    logic [NUM_DIGITS*CODE_W-1:0] active;
    logic [NUM_DIGITS-1:0]        lz_blank;
    logic                         lz_run;
    logic [OT_W-1:0]              on_prod;
    logic [OT_W-1:0]              on_time;
    logic                         slot_on;
    logic [6:0]                   seg_dec;

    // Prescaler and digit select
    assign count_en  = (pre == PRE_W'(DIV - 1));
    assign last_dig  = (count_out == SEL_W'(NUM_DIGITS - 1));
    assign frame_end = count_en & last_dig;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre       <= '0;
            count_out <= '0;
        end else begin
            pre <= count_en ? '0 : pre + 1'b1;
            if (count_en)
                count_out <= last_dig ? '0 : count_out + 1'b1;
        end
    end

    // Double buffer: active only changes on a frame boundary, so a frame
    // is always drawn from one consistent set of digits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            staging  <= '0;
            active   <= '0;
            pending  <= 1'b0;
            load_ack <= 1'b0;
        end else begin
            load_ack <= frame_end & (pending | load);
            if (frame_end) begin
                // A load on the boundary itself bypasses staging
                if (load)
                    active <= digits;
                else if (pending)
                    active <= staging;
                pending <= 1'b0;
            end else if (load) begin
                staging <= digits;
                pending <= 1'b1;
            end
        end
    end

    assign D_out = active[count_out*CODE_W +: CODE_W];

    // Leading zeros: blank runs from the top digit while value==0 and
    // no DP; digit 0 is never part of the run.
    always_comb begin
        lz_blank = '0;
        lz_run   = lz_en;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz_run = lz_run
                   & (active[i*CODE_W+VAL_LSB +: 4] == 4'd0)
                   & ~active[i*CODE_W+DP_BIT];
            lz_blank[i] = lz_run;
        end
    end

    // PWM: anode enabled for the first on_time cycles of each slot
    assign on_prod = (OT_W'(bright) + OT_W'(1)) * OT_W'(DIV);
    assign on_time = on_prod >> BRIGHT_W;
    assign slot_on = (OT_W'(pre) < on_time)
                   & ~D_out[BLANK_BIT]
                   & ~lz_blank[count_out];

    sseg_hex_decoder u_hex (
        .hex (D_out[VAL_LSB +: 4]),
        .seg (seg_dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            AN   <= '1;
            sseg <= SEG_BLANK;
            DP   <= 1'b1;
        end else if (slot_on) begin
            AN   <= ~(NUM_DIGITS'(1) << count_out);
            sseg <= seg_dec;
            DP   <= ~D_out[DP_BIT];
        end else begin
            AN   <= '1;
            sseg <= SEG_BLANK;
            DP   <= 1'b1;
        end
    end

endmodule
